// File: rtl/pipeline_pkg.sv
// Shared MEM-stage definitions: load/store funct3 encodings, LSU state type and
// access classification helpers.
package pipeline_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_LH, F3_LHU: mis = off[0];
            F3_LW:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-enable/data replication and load
// byte/half extraction with sign or zero extension.
module lsu_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be    = 4'h0;
        wdata = st_data;
        case (st_funct3)
            F3_LB, F3_LBU: begin
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            F3_LH, F3_LHU: begin
                be    = 4'b0011 << st_off;
                wdata = {2{st_data[15:0]}};
            end
            F3_LW:   be = 4'hF;
            default: be = 4'h0;
        endcase
    end

    always_comb begin
        byte_sel = rdata[{ld_off, 3'b000} +: 8];
        half_sel = rdata[{ld_off[1], 4'b0000} +: 16];
        case (ld_funct3)
            F3_LB:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  ld_ext = {24'h0, byte_sel};
            F3_LH:   ld_ext = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  ld_ext = {16'h0, half_sel};
            F3_LW:   ld_ext = rdata;
            default: ld_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns an M-stage load/store into a req/ack bus
// transaction, stalling the pipeline until the access completes or times out.
module mem_lsu
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        insn_vld_M,
    input  logic        flush_M,
    input  logic        mem_rd_M,
    input  logic        mem_wr_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] alu_data_M,
    input  logic [31:0] st_data_M,
    output logic [31:0] ld_data_M,
    output logic        stall_M,
    output logic        misalign_M,
    output logic        bus_err_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d, we_q, we_d, berr_q, berr_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic          access, misaligned;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata, ld_ext;

    assign access     = insn_vld_M & (mem_rd_M | mem_wr_M) & ~flush_M & f3_legal(funct3_M);
    assign misaligned = f3_misaligned(funct3_M, alu_data_M[1:0]);

    lsu_align u_align (
        .st_funct3 (funct3_M),
        .st_off    (alu_data_M[1:0]),
        .st_data   (st_data_M),
        .be        (st_be),
        .wdata     (st_wdata),
        .ld_funct3 (f3_q),
        .ld_off    (off_q),
        .rdata     (dmem_rdata),
        .ld_ext    (ld_ext)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        off_d      = off_q;
        ld_d       = ld_q;
        berr_d     = 1'b0;
        stall_M    = 1'b0;
        misalign_M = 1'b0;
        case (state_q)
            IDLE: begin
                ld_d  = 32'h0;
                cnt_d = '0;
                if (access) begin
                    if (misaligned) begin
                        misalign_M = 1'b1;
                    end else begin
                        stall_M = 1'b1;
                        req_d   = 1'b1;
                        we_d    = mem_wr_M;
                        addr_d  = {alu_data_M[31:2], 2'b00};
                        be_d    = st_be;
                        wdata_d = st_wdata;
                        f3_d    = funct3_M;
                        off_d   = alu_data_M[1:0];
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_M = 1'b1;
                // An ack on the final allowed cycle still completes normally.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    ld_d    = we_q ? 32'h0 : ld_ext;
                    state_d = DONE;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    req_d   = 1'b0;
                    ld_d    = 32'h0;
                    berr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            ld_q    <= 32'h0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            ld_q    <= ld_d;
            berr_q  <= berr_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign ld_data_M  = ld_q;
    assign bus_err_M  = berr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, loads, misalignment, timeout, mid-flight
// reset and flush, each checked against hand-computed values.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        insn_vld_M, flush_M, mem_rd_M, mem_wr_M;
    logic [2:0]  funct3_M;
    logic [31:0] alu_data_M, st_data_M;
    logic [31:0] ld_data_M;
    logic        stall_M, misalign_M, bus_err_M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .insn_vld_M (insn_vld_M),
        .flush_M    (flush_M),
        .mem_rd_M   (mem_rd_M),
        .mem_wr_M   (mem_wr_M),
        .funct3_M   (funct3_M),
        .alu_data_M (alu_data_M),
        .st_data_M  (st_data_M),
        .ld_data_M  (ld_data_M),
        .stall_M    (stall_M),
        .misalign_M (misalign_M),
        .bus_err_M  (bus_err_M),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic fl);
        insn_vld_M = 1'b1;
        mem_rd_M   = rd;
        mem_wr_M   = wr;
        funct3_M   = f3;
        alu_data_M = a;
        st_data_M  = d;
        flush_M    = fl;
    endtask

    task automatic idle_in();
        insn_vld_M = 1'b0;
        mem_rd_M   = 1'b0;
        mem_wr_M   = 1'b0;
        flush_M    = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        idle_in();
        funct3_M   = 3'b000;
        alu_data_M = 32'h0;
        st_data_M  = 32'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #12;
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall_M}, 32'h0);
        chk("rst_ld", ld_data_M, 32'h0);
        chk("rst_be", {28'h0, dmem_be}, 32'h0);
        chk("rst_berr", {31'h0, bus_err_M}, 32'h0);
        rst_n = 1'b1;

        // SW 0x104, ack on second REQ cycle
        tick(); issue(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b0); settle();
        chk("sw_idle_stall", {31'h0, stall_M}, 32'h1);
        chk("sw_idle_req", {31'h0, dmem_req}, 32'h0);
        tick(); idle_in(); settle();
        chk("sw_req", {31'h0, dmem_req}, 32'h1);
        chk("sw_addr", dmem_addr, 32'h104);
        chk("sw_be", {28'h0, dmem_be}, 32'hF);
        chk("sw_we", {31'h0, dmem_we}, 32'h1);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw_req1_stall", {31'h0, stall_M}, 32'h1);
        tick(); dmem_ack = 1'b1; settle();
        chk("sw_req2_stall", {31'h0, stall_M}, 32'h1);
        chk("sw_req2_req", {31'h0, dmem_req}, 32'h1);
        tick(); dmem_ack = 1'b0; settle();
        chk("sw_done_stall", {31'h0, stall_M}, 32'h0);
        chk("sw_done_req", {31'h0, dmem_req}, 32'h0);
        chk("sw_done_ld", ld_data_M, 32'h0);

        // LB 0x203, ack on first REQ cycle
        tick(); issue(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 1'b0); settle();
        chk("lb_idle_stall", {31'h0, stall_M}, 32'h1);
        tick(); idle_in(); dmem_ack = 1'b1; dmem_rdata = 32'h80AABBCC; settle();
        chk("lb_be", {28'h0, dmem_be}, 32'h8);
        chk("lb_addr", dmem_addr, 32'h200);
        chk("lb_we", {31'h0, dmem_we}, 32'h0);
        tick(); dmem_ack = 1'b0; settle();
        chk("lb_ld", ld_data_M, 32'hFFFFFF80);
        chk("lb_done_stall", {31'h0, stall_M}, 32'h0);

        // LBU 0x203
        tick(); issue(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 1'b0); settle();
        tick(); idle_in(); dmem_ack = 1'b1; settle();
        tick(); dmem_ack = 1'b0; settle();
        chk("lbu_ld", ld_data_M, 32'h00000080);

        // LH misaligned
        tick(); issue(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 1'b0); settle();
        chk("lh_mis", {31'h0, misalign_M}, 32'h1);
        chk("lh_mis_stall", {31'h0, stall_M}, 32'h0);
        tick(); idle_in(); settle();
        chk("lh_mis_clr", {31'h0, misalign_M}, 32'h0);
        chk("lh_mis_noreq", {31'h0, dmem_req}, 32'h0);

        // LW never acked -> timeout after 4 REQ cycles
        tick(); issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b0); dmem_rdata = 32'h12345678;
        settle();
        for (int i = 0; i < 4; i++) begin
            tick(); idle_in(); settle();
            chk($sformatf("to_req%0d", i), {31'h0, dmem_req}, 32'h1);
            chk($sformatf("to_stall%0d", i), {31'h0, stall_M}, 32'h1);
        end
        tick(); settle();
        chk("to_req_drop", {31'h0, dmem_req}, 32'h0);
        chk("to_berr", {31'h0, bus_err_M}, 32'h1);
        chk("to_ld", ld_data_M, 32'h0);
        chk("to_done_stall", {31'h0, stall_M}, 32'h0);
        tick(); settle();
        chk("to_berr_clr", {31'h0, bus_err_M}, 32'h0);

        // Reset while in REQ
        tick(); issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b0); settle();
        tick(); idle_in(); settle();
        chk("rr_req", {31'h0, dmem_req}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_req_drop", {31'h0, dmem_req}, 32'h0);
        chk("rr_stall", {31'h0, stall_M}, 32'h0);
        #2 rst_n = 1'b1;
        tick(); issue(1'b0, 1'b1, 3'b000, 32'h401, 32'h00000055, 1'b0); settle();
        chk("rr_sb_stall", {31'h0, stall_M}, 32'h1);
        tick(); idle_in(); dmem_ack = 1'b1; settle();
        chk("rr_sb_be", {28'h0, dmem_be}, 32'h2);
        chk("rr_sb_wdata", dmem_wdata, 32'h55555555);
        tick(); dmem_ack = 1'b0; settle();
        chk("rr_sb_done", {31'h0, stall_M}, 32'h0);

        // SH flushed, then unflushed
        tick(); issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1'b1); settle();
        chk("fl_stall", {31'h0, stall_M}, 32'h0);
        tick(); flush_M = 1'b0; settle();
        chk("fl_noreq", {31'h0, dmem_req}, 32'h0);
        chk("sh_stall", {31'h0, stall_M}, 32'h1);
        tick(); idle_in(); dmem_ack = 1'b1; settle();
        chk("sh_req", {31'h0, dmem_req}, 32'h1);
        chk("sh_be", {28'h0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        tick(); dmem_ack = 1'b0; settle();
        chk("sh_done", {31'h0, stall_M}, 32'h0);

        // Illegal funct3 is a no-op
        tick(); issue(1'b1, 1'b0, 3'b011, 32'h500, 32'h0, 1'b0); settle();
        chk("ill_stall", {31'h0, stall_M}, 32'h0);
        tick(); idle_in(); settle();
        chk("ill_req", {31'h0, dmem_req}, 32'h0);
        chk("ill_ld", ld_data_M, 32'h0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
